// File: rtl/three_bits_in_pkg.sv
`default_nettype none
// ============================================================================
// Module      : three_bits_in_pkg
// Description : Shared constants and types for the three-wire bit receiver.
//               EV_TIME_W - timestamp width, NBITS - pin count,
//               TOP/MID/BOT - bit positions of each pin in the 3-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
package three_bits_in_pkg;

  localparam int EV_TIME_W = 16;
  localparam int NBITS     = 3;

  localparam int TOP = 2;
  localparam int MID = 1;
  localparam int BOT = 0;

  typedef logic [NBITS-1:0]     bits_t;
  typedef logic [EV_TIME_W-1:0] stamp_t;

  // Contents of the event holding register.
  typedef struct packed {
    bits_t  bits;
    stamp_t stamp;
  } event_t;

endpackage
`default_nettype wire

// File: rtl/three_bits_in_if.sv
`default_nettype none
// ============================================================================
// Module      : three_bits_in_if
// Description : Valid/ready event port of the three-wire bit receiver.
//               ev_valid  - holding register full (master -> slave)
//               ev_ready  - consumer accepts event (slave -> master)
//               ev_bits   - debounced value after the change
//               ev_time   - timestamp at which the level changed
// Revision    : 1.0 - initial release
// ============================================================================
interface three_bits_in_if;
  import three_bits_in_pkg::*;

  logic   ev_valid;
  logic   ev_ready;
  bits_t  ev_bits;
  stamp_t ev_time;

  modport master (output ev_valid, output ev_bits, output ev_time, input  ev_ready);
  modport slave  (input  ev_valid, input  ev_bits, input  ev_time, output ev_ready);

endinterface
`default_nettype wire

// File: rtl/three_bits_in_bit_debounce.sv
`default_nettype none
// ============================================================================
// Module      : bit_debounce
// Description : One-bit synchroniser chain followed by a debounce counter.
//               clk, rst_n  - system clock, async active-low reset
//               pin         - asynchronous input pin
//               level       - debounced level (registered)
//               level_nxt   - value level takes on the coming edge
// Revision    : 1.0 - initial release
// ============================================================================
module bit_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  pin,
  output logic level,
  output logic level_nxt
);

  localparam int c_cnt_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_level;
  logic                   w_s;
  logic                   w_diff;
  logic                   w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_s != r_level);
  // The edge on which the count would reach DEBOUNCE is the accepting edge,
  // so the counter itself never holds DEBOUNCE.
  assign w_hit  = w_diff && (r_cnt == c_cnt_w'(DEBOUNCE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      if (!w_diff || w_hit) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
      if (w_hit) r_level <= w_s;
    end
  end

  assign level     = r_level;
  assign level_nxt = w_hit ? w_s : r_level;

endmodule
`default_nettype wire

// File: rtl/three_bits_in.sv
`default_nettype none
// ============================================================================
// Module      : three_bits_in
// Description : Receive end of the three-wire bit interface. Debounces the
//               top/middle/bottom pins and reports each change of the 3-bit
//               level as a timestamped event; keeps per-bit rise counts.
//               clk, rst_n    - system clock, async active-low reset
//               top/middle/bottom - async pins (bits 2/1/0)
//               level         - debounced {top,middle,bottom}
//               ev            - event port (valid/ready, bits, time)
//               overflow      - sticky, an event was dropped
//               clr_overflow  - clears overflow (a same-edge drop wins)
//               rise_cnt      - {top,middle,bottom} saturating rise counts
// Revision    : 1.0 - initial release
// ============================================================================
module three_bits_in
  import three_bits_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  wire                      clk,
  input  wire                      rst_n,
  input  wire                      top,
  input  wire                      middle,
  input  wire                      bottom,
  output logic [NBITS-1:0]         level,
  three_bits_in_if.master          ev,
  output logic                     overflow,
  input  wire                      clr_overflow,
  output logic [NBITS*CNT_W-1:0]   rise_cnt
);

  bits_t  w_pins;
  bits_t  w_level;
  bits_t  w_level_nxt;
  logic   w_chg;
  logic   w_xfer;
  logic   w_load;
  logic   w_drop;

  stamp_t r_ts;
  event_t r_ev;
  logic   r_ev_valid;
  logic   r_overflow;

  assign w_pins[TOP] = top;
  assign w_pins[MID] = middle;
  assign w_pins[BOT] = bottom;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    bit_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin       (w_pins[i]),
      .level     (w_level[i]),
      .level_nxt (w_level_nxt[i])
    );
  end

  // All bits flipping on the same edge collapse into one event.
  assign w_chg  = (w_level_nxt != w_level);
  assign w_xfer = r_ev_valid && ev.ev_ready;
  // Back-to-back: a transfer on the same edge frees the slot for the new event.
  assign w_load = w_chg && (!r_ev_valid || w_xfer);
  assign w_drop = w_chg && !w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ev_valid <= 1'b0;
      r_ev       <= '0;
    end else if (w_load) begin
      r_ev_valid <= 1'b1;
      r_ev       <= '{bits: w_level_nxt, stamp: r_ts};
    end else if (w_xfer) begin
      r_ev_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (clr_overflow) r_overflow <= 1'b0;
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_cnt <= '0;
      else if (w_level_nxt[i] && !w_level[i] && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
    assign rise_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end

  assign level       = w_level;
  assign overflow    = r_overflow;
  assign ev.ev_valid = r_ev_valid;
  assign ev.ev_bits  = r_ev.bits;
  assign ev.ev_time  = r_ev.stamp;

endmodule
`default_nettype wire

// File: tb/tb_three_bits_in.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_three_bits_in
// Description : Self-checking bench for three_bits_in (scoreboarded events).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_three_bits_in;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        top, middle, bottom, clr_overflow;
  logic [2:0]  level, level2;
  logic        overflow, overflow2;
  logic [23:0] rise_cnt;
  logic [5:0]  rise_cnt2;

  three_bits_in_if evif ();
  three_bits_in_if evif2 ();

  always #5 clk = ~clk;

  three_bits_in u_dut (
    .clk (clk), .rst_n (rst_n), .top (top), .middle (middle), .bottom (bottom),
    .level (level), .ev (evif), .overflow (overflow),
    .clr_overflow (clr_overflow), .rise_cnt (rise_cnt)
  );

  three_bits_in #(.CNT_W (2)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .top (top), .middle (middle), .bottom (bottom),
    .level (level2), .ev (evif2), .overflow (overflow2),
    .clr_overflow (clr_overflow), .rise_cnt (rise_cnt2)
  );

  typedef struct {
    logic [2:0]  bits;
    logic [15:0] stamp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edges since reset release; equals the DUT timestamp after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin change driven now is seen on the next edge; level moves 6 edges
  // later, and the reported time is the count before that edge.
  task automatic push(input logic [2:0] bits);
    exp_t e;
    e.bits  = bits;
    e.stamp = 16'(cyc + 5);
    sb.push_back(e);
  endtask

  // Inputs change at posedge+1, so values here are the ones the next edge uses.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evif.ev_valid && evif.ev_ready) begin
      if (sb.size() == 0) begin
        check("ev_unexpected", {29'd0, evif.ev_bits}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("ev_bits", {29'd0, evif.ev_bits}, {29'd0, mon_e.bits});
        check("ev_time", {16'd0, evif.ev_time}, {16'd0, mon_e.stamp});
      end
    end
  end

  initial begin
    evif2.ev_ready = 1'b1;
    evif.ev_ready  = 1'b0;
    rst_n = 1'b0; top = 1'b0; middle = 1'b0; bottom = 1'b0; clr_overflow = 1'b0;
    #23 rst_n = 1'b1;

    // Quiet after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_level", level, 3'b000);
      check("rst_valid", evif.ev_valid, 1'b0);
      check("rst_rise", rise_cnt, 24'd0);
      check("rst_ovf", overflow, 1'b0);
    end

    // Single top step: exact latency and one-cycle pulse
    evif.ev_ready = 1'b1;
    top = 1'b1;
    push(3'b100);
    tick(5);
    check("lat_before", level, 3'b000);
    tick();
    check("lat_at", level, 3'b100);
    check("pulse_hi", evif.ev_valid, 1'b1);
    tick();
    check("pulse_lo", evif.ev_valid, 1'b0);
    check("rise_top1", rise_cnt, {8'd1, 8'd0, 8'd0});

    // Glitch shorter than the debounce window
    middle = 1'b1;
    tick(3);
    middle = 1'b0;
    tick(12);
    check("glitch_level", level, 3'b100);
    check("glitch_valid", evif.ev_valid, 1'b0);
    check("glitch_rise", rise_cnt, {8'd1, 8'd0, 8'd0});

    // Backpressure: held event, dropped event, overflow
    evif.ev_ready = 1'b0;
    top = 1'b0;
    push(3'b000);
    tick(6);
    check("hold_valid", evif.ev_valid, 1'b1);
    check("hold_bits0", evif.ev_bits, sb[0].bits);
    check("hold_time0", evif.ev_time, sb[0].stamp);
    tick(4);
    check("hold_bits1", evif.ev_bits, sb[0].bits);
    check("hold_time1", evif.ev_time, sb[0].stamp);
    bottom = 1'b1;
    tick(8);
    check("drop_level", level, 3'b001);
    check("drop_ovf", overflow, 1'b1);
    check("drop_valid", evif.ev_valid, 1'b1);
    check("drop_bits", evif.ev_bits, sb[0].bits);
    check("drop_time", evif.ev_time, sb[0].stamp);
    evif.ev_ready = 1'b1;
    tick();
    check("drain_valid", evif.ev_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // Two bits changing on the same cycle form one event
    bottom = 1'b0;
    push(3'b000);
    tick(10);
    top = 1'b1;
    bottom = 1'b1;
    push(3'b101);
    tick(6);
    check("same_level", level, 3'b101);
    tick(2);
    check("same_rise", rise_cnt, {8'd2, 8'd0, 8'd2});
    check("same_rise2", rise_cnt2, {2'd2, 2'd0, 2'd2});

    // Saturation on the narrow-counter instance
    for (int k = 0; k < 5; k++) begin
      top = 1'b0;
      push(3'b001);
      tick(8);
      top = 1'b1;
      push(3'b101);
      tick(8);
      if (k == 0) check("sat_first", rise_cnt2[5:4], 2'd3);
    end
    check("sat_top2", rise_cnt2[5:4], 2'd3);
    check("sat_bot2", rise_cnt2[1:0], 2'd2);
    check("wide_top", rise_cnt[23:16], 8'd7);

    // Timestamp wrap: level change on the FFFF->0000 edge, then one after it
    while (cyc < 32'h0000_FFFA) tick();
    middle = 1'b1;
    push(3'b111);
    tick(8);
    check("wrap_level", level, 3'b111);
    check("wrap_rise", rise_cnt[15:8], 8'd1);
    middle = 1'b0;
    push(3'b101);
    tick(8);

    // Reset while an event is pending
    evif.ev_ready = 1'b0;
    middle = 1'b1;
    tick(8);
    check("pend_valid", evif.ev_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_level", level, 3'b000);
    check("arst_valid", evif.ev_valid, 1'b0);
    check("arst_bits", evif.ev_bits, 3'b000);
    check("arst_time", evif.ev_time, 16'd0);
    check("arst_ovf", overflow, 1'b0);
    check("arst_rise", rise_cnt, 24'd0);
    tick(2);
    rst_n = 1'b1;
    evif.ev_ready = 1'b1;
    push(3'b111);
    tick(5);
    check("rel_before", level, 3'b000);
    tick();
    check("rel_level", level, 3'b111);
    tick(2);
    check("rel_valid", evif.ev_valid, 1'b0);
    check("rel_rise", rise_cnt, {8'd1, 8'd1, 8'd1});

    tick(4);
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
